// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte stream among N_REQ sources.
// 1-cycle arbitration, then zero-latency passthrough; engine backpressure reaches the owner only.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_fifo_data,
  output logic               tx_fifo_valid,
  input  logic               tx_fifo_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [15:0]        pkt_count,
  output logic               timeout_pulse,
  output logic [7:0]         timeout_count
);

  localparam int GW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [WW-1:0] wd_cnt;

  logic [GW-1:0] pick;
  logic          pick_vld;
  logic [GW-1:0] idx_l;
  int            idx;

  logic          own_vld;
  logic          own_last;
  logic          xfer;

  // Walk downward so the nearest requester after last_grant is the final (winning) assignment.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    idx_l    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx   = (int'(last_grant) + k) % N_REQ;
      idx_l = GW'(idx);
      if (req_valid[idx_l]) begin
        pick     = idx_l;
        pick_vld = 1'b1;
      end
    end
  end

  // While BUSY, last_grant is the owner index.
  assign own_vld       = req_valid[last_grant];
  assign own_last      = req_last[last_grant];
  assign busy          = (state == BUSY);
  assign tx_fifo_valid = busy & own_vld;
  assign tx_fifo_data  = busy ? req_data[{last_grant, 3'b000} +: 8] : 8'h00;
  assign req_ready     = grant & {N_REQ{tx_fifo_ready}};
  assign xfer          = tx_fifo_valid & tx_fifo_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= GW'(N_REQ - 1);
      wd_cnt        <= '0;
      pkt_count     <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (pick_vld) begin
            grant      <= N_REQ'(1) << pick;
            last_grant <= pick;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            wd_cnt <= '0;
            if (own_last) begin
              pkt_count <= pkt_count + 16'd1;
              grant     <= '0;
              state     <= IDLE;
            end
          end else if (!own_vld) begin
            // Owner stall: release on the edge where the counter would reach TIMEOUT-1.
            if (wd_cnt == WW'(TIMEOUT - 2)) begin
              wd_cnt        <= '0;
              grant         <= '0;
              state         <= IDLE;
              timeout_pulse <= 1'b1;
              if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle corner sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_data = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_valid;
  logic        tx_fifo_ready = 1'b1;
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] pkt_count;
  logic        timeout_pulse;
  logic [7:0]  timeout_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_valid(tx_fifo_valid), .tx_fifo_ready(tx_fifo_ready),
    .grant(grant), .busy(busy), .pkt_count(pkt_count),
    .timeout_pulse(timeout_pulse), .timeout_count(timeout_count)
  );

  typedef struct packed {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] dat;
    logic        rdy;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [3:0]  e_grant;
    logic [3:0]  e_rrdy;
    logic        e_busy;
    logic [15:0] e_pkt;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic rd, input logic txv,
                              input logic [7:0] txd, input logic [3:0] g, input logic [3:0] rr,
                              input logic b, input logic [15:0] p);
    vec_t x;
    x.rst = r; x.vld = v; x.last = l; x.dat = d; x.rdy = rd;
    x.e_txv = txv; x.e_txd = txd; x.e_grant = g; x.e_rrdy = rr; x.e_busy = b; x.e_pkt = p;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0; tx_fifo_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int got, cnt0, cnt1, bad, found;

    // rst, vld, last, data{r3,r2,r1,r0}, rdy | txv, txd, grant, req_ready, busy, pkt
    tbl[0]  = mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 0);
    tbl[1]  = mk(0, 4'b0010, 4'b0000, 32'h0000_A100, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 4'b0010, 4'b0000, 32'h0000_A100, 1, 1, 8'hA1, 4'b0010, 4'b0010, 1, 0);
    tbl[3]  = mk(0, 4'b0010, 4'b0000, 32'h0000_A200, 1, 1, 8'hA2, 4'b0010, 4'b0010, 1, 0);
    tbl[4]  = mk(0, 4'b0010, 4'b0010, 32'h0000_A300, 1, 1, 8'hA3, 4'b0010, 4'b0010, 1, 0);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 1);
    tbl[6]  = mk(1, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 0);
    tbl[7]  = mk(0, 4'b0101, 4'b0000, 32'h0030_0010, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 0);
    tbl[8]  = mk(0, 4'b0101, 4'b0000, 32'h0030_0010, 1, 1, 8'h10, 4'b0001, 4'b0001, 1, 0);
    tbl[9]  = mk(0, 4'b0101, 4'b0001, 32'h0030_0011, 1, 1, 8'h11, 4'b0001, 4'b0001, 1, 0);
    tbl[10] = mk(0, 4'b0100, 4'b0000, 32'h0030_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 1);
    tbl[11] = mk(0, 4'b0101, 4'b0000, 32'h0030_0055, 1, 1, 8'h30, 4'b0100, 4'b0100, 1, 1);
    tbl[12] = mk(0, 4'b0101, 4'b0100, 32'h0031_0055, 0, 1, 8'h31, 4'b0100, 4'b0000, 1, 1);
    tbl[13] = mk(0, 4'b0101, 4'b0100, 32'h0031_0055, 1, 1, 8'h31, 4'b0100, 4'b0100, 1, 1);
    tbl[14] = mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0, 2);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; req_valid = tbl[i].vld; req_last = tbl[i].last;
      req_data = tbl[i].dat; tx_fifo_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d txv", i),   32'(tx_fifo_valid), 32'(tbl[i].e_txv));
      chk($sformatf("v%0d txd", i),   32'(tx_fifo_data),  32'(tbl[i].e_txd));
      chk($sformatf("v%0d grant", i), 32'(grant),         32'(tbl[i].e_grant));
      chk($sformatf("v%0d rrdy", i),  32'(req_ready),     32'(tbl[i].e_rrdy));
      chk($sformatf("v%0d busy", i),  32'(busy),          32'(tbl[i].e_busy));
      chk($sformatf("v%0d pkt", i),   32'(pkt_count),     32'(tbl[i].e_pkt));
    end

    // Fairness: two sources streaming 1-byte packets must alternate.
    reset_dut();
    req_valid = 4'b0011; req_last = 4'b0011; req_data = 32'h0000_B1B0;
    got = 0; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      @(negedge clk); #1;
      if (tx_fifo_valid && tx_fifo_ready) begin
        chk($sformatf("fair grant %0d", got), 32'(grant), (got % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("fair data %0d", got), 32'(tx_fifo_data), (got % 2 == 0) ? 32'hB0 : 32'hB1);
        if (grant == 4'b0001) cnt0++;
        if (grant == 4'b0010) cnt1++;
        got++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    chk("fair transfers", 32'(got), 32'd20);
    chk("fair count r0", 32'(cnt0), 32'd10);
    chk("fair count r1", 32'(cnt1), 32'd10);
    chk("fair pkt_count", 32'(pkt_count), 32'd20);

    // Engine backpressure for 2000 cycles must not trigger the watchdog.
    reset_dut();
    req_valid = 4'b1000; req_data = 32'hC000_0000; tx_fifo_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp first byte", {23'd0, tx_fifo_valid, tx_fifo_data}, {23'd0, 1'b1, 8'hC0});
    @(negedge clk);
    req_data = 32'hC100_0000; req_last = 4'b1000; tx_fifo_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      #1;
      if (!(tx_fifo_valid && tx_fifo_data == 8'hC1 && grant == 4'b1000 &&
            req_ready == 4'b0000 && !timeout_pulse)) bad++;
      @(negedge clk);
    end
    chk("bp stall cycles bad", 32'(bad), 32'd0);
    tx_fifo_ready = 1'b1; #1;
    chk("bp ready after", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0; req_last = '0; #1;
    chk("bp pkt_count", 32'(pkt_count), 32'd1);
    chk("bp timeout_count", 32'(timeout_count), 32'd0);
    chk("bp busy", 32'(busy), 32'd0);

    // Watchdog: owner stalls after one byte; requester 1 is waiting.
    reset_dut();
    req_valid = 4'b0100; req_data = 32'h00D0_0000;
    @(negedge clk); @(negedge clk); #1;
    chk("wd byte", {23'd0, tx_fifo_valid, tx_fifo_data}, {23'd0, 1'b1, 8'hD0});
    @(posedge clk); #1;
    req_valid = 4'b0010; req_last = 4'b0010; req_data = 32'h0000_E000;
    found = 0;
    for (int n = 1; n <= 40 && found == 0; n++) begin
      @(posedge clk); #1;
      if (timeout_pulse) found = n;
    end
    chk("wd pulse delay", 32'(found), 32'd15);
    chk("wd grant at pulse", 32'(grant), 32'd0);
    chk("wd busy at pulse", 32'(busy), 32'd0);
    chk("wd timeout_count", 32'(timeout_count), 32'd1);
    chk("wd pkt_count", 32'(pkt_count), 32'd0);
    @(posedge clk); #1;
    chk("wd pulse width", 32'(timeout_pulse), 32'd0);
    chk("wd next grant", 32'(grant), 32'h2);

    // Reset in the middle of a 4-byte packet.
    reset_dut();
    req_valid = 4'b0001; req_data = 32'h0000_00F0;
    @(negedge clk); @(negedge clk);
    req_data = 32'h0000_00F1;
    @(negedge clk);
    req_data = 32'h0000_00F2; req_valid = 4'b0011;
    rst = 1'b1; #1;
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst txv", 32'(tx_fifo_valid), 32'd0);
    chk("rst txd", 32'(tx_fifo_data), 32'd0);
    chk("rst rrdy", 32'(req_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post-rst grant", 32'(grant), 32'h1);
    chk("post-rst pkt_count", 32'(pkt_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
